// File: rtl/ldm_sequencer.sv
// Decode-stage LDM/STM expander: issues one single-register load/store micro-op
// per cycle, lowest register first, stalling Fetch/Decode until the last one.
module ldm_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        armD,
  input  logic        validD,
  input  logic [31:0] instrD,
  input  logic        stallD,
  input  logic        flushD,
  output logic        seq_stall,
  output logic        uop_valid,
  output logic [3:0]  uop_reg,
  output logic        uop_load,
  output logic        uop_first,
  output logic        uop_last,
  output logic [31:0] uop_offset,
  output logic        uop_wb,
  output logic [31:0] wb_offset
);

  typedef enum logic {IDLE, SEQ} state_e;

  typedef struct packed {
    logic        stall;
    logic        valid;
    logic [3:0]  rd;
    logic        load;
    logic        first;
    logic        last;
    logic [31:0] offset;
    logic        wb;
    logic [31:0] wboff;
  } uop_t;

  state_e      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [31:0] off_q, off_d;
  logic [31:0] wboff_q, wboff_d;
  logic        load_q, load_d;
  logic        wb_q, wb_d;
  uop_t        hold_q, hold_d;

  logic        detect;
  logic [4:0]  cnt;
  logic [31:0] four_n;
  logic [31:0] start_off;
  logic [15:0] src_mask;
  logic [15:0] rest;
  logic [31:0] src_off;
  logic [31:0] src_wboff;
  logic        src_load;
  logic        src_wb;
  logic        first;
  logic        active;
  logic        is_last;
  logic        found;
  logic [3:0]  idx;
  uop_t        cur;
  uop_t        outp;
  uop_t        drv;

  // Condition field and S bit play no part in sequencing.
  logic unused_bits;
  assign unused_bits = ^{instrD[31:28], instrD[22]};

  always_comb begin : decode
    detect = armD & validD & (instrD[27:25] == 3'b100);
    cnt    = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cnt = cnt + 5'(instrD[i]);
    end
    four_n    = {25'd0, cnt, 2'b00};
    start_off = (instrD[23] ? 32'd0 : -four_n)
              + ((instrD[24] == instrD[23]) ? 32'd4 : 32'd0);
  end

  always_comb begin : select
    if (state_q == SEQ) begin
      src_mask  = mask_q;
      src_off   = off_q;
      src_load  = load_q;
      src_wb    = wb_q;
      src_wboff = wboff_q;
      first     = 1'b0;
      active    = (mask_q != '0);
    end else begin
      src_mask  = instrD[15:0];
      src_off   = start_off;
      src_load  = instrD[20];
      src_wb    = instrD[21];
      src_wboff = instrD[23] ? four_n : -four_n;
      first     = 1'b1;
      active    = detect & (cnt != '0);
    end
    rest    = src_mask & (src_mask - 16'd1);
    is_last = (rest == '0);
    idx     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (src_mask[i] && !found) begin
        idx   = 4'(i);
        found = 1'b1;
      end
    end
    cur = '0;
    if (active) begin
      cur.stall  = ~is_last;
      cur.valid  = 1'b1;
      cur.rd     = idx;
      cur.load   = src_load;
      cur.first  = first;
      cur.last   = is_last;
      cur.offset = src_off;
      cur.wb     = src_wb & is_last;
      cur.wboff  = src_wboff;
    end
  end

  // A stalled cycle replays the last issued outputs with valid dropped.
  always_comb begin : next_state
    state_d = state_q;
    mask_d  = mask_q;
    off_d   = off_q;
    wboff_d = wboff_q;
    load_d  = load_q;
    wb_d    = wb_q;
    hold_d  = hold_q;
    outp    = cur;
    if (flushD) begin
      state_d = IDLE;
      mask_d  = '0;
      outp    = '0;
      hold_d  = '0;
    end else if (stallD) begin
      outp       = hold_q;
      outp.valid = 1'b0;
    end else begin
      hold_d = cur;
      if (active && !is_last) begin
        state_d = SEQ;
        mask_d  = rest;
        off_d   = src_off + 32'd4;
        load_d  = src_load;
        wb_d    = src_wb;
        wboff_d = src_wboff;
      end else begin
        state_d = IDLE;
        mask_d  = '0;
      end
    end
    drv = reset_n ? outp : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      off_q   <= '0;
      wboff_q <= '0;
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
      wboff_q <= wboff_d;
      load_q  <= load_d;
      wb_q    <= wb_d;
      hold_q  <= hold_d;
    end
  end

  assign seq_stall  = drv.stall;
  assign uop_valid  = drv.valid;
  assign uop_reg    = drv.rd;
  assign uop_load   = drv.load;
  assign uop_first  = drv.first;
  assign uop_last   = drv.last;
  assign uop_offset = drv.offset;
  assign uop_wb     = drv.wb;
  assign wb_offset  = drv.wboff;

endmodule

// File: tb/tb_ldm_sequencer.sv
// Self-checking bench for ldm_sequencer: directed LDM/STM cases plus random
// instructions checked against a register-list/offset reference model.
module tb_ldm_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        armD = 1'b0;
  logic        validD = 1'b0;
  logic [31:0] instrD = '0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic        seq_stall;
  logic        uop_valid;
  logic [3:0]  uop_reg;
  logic        uop_load;
  logic        uop_first;
  logic        uop_last;
  logic [31:0] uop_offset;
  logic        uop_wb;
  logic [31:0] wb_offset;

  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs for the cycle being checked.
  logic        e_stall, e_valid, e_load, e_first, e_last, e_wb, e_cmp_wbo;
  logic [3:0]  e_reg;
  logic [31:0] e_off, e_wbo;

  ldm_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .armD      (armD),
    .validD    (validD),
    .instrD    (instrD),
    .stallD    (stallD),
    .flushD    (flushD),
    .seq_stall (seq_stall),
    .uop_valid (uop_valid),
    .uop_reg   (uop_reg),
    .uop_load  (uop_load),
    .uop_first (uop_first),
    .uop_last  (uop_last),
    .uop_offset(uop_offset),
    .uop_wb    (uop_wb),
    .wb_offset (wb_offset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_zero();
    e_stall = 0; e_valid = 0; e_reg = '0; e_load = 0; e_first = 0;
    e_last = 0; e_off = '0; e_wb = 0; e_wbo = '0; e_cmp_wbo = 1;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".seq_stall"},  32'(seq_stall),  32'(e_stall));
    chk({ctx, ".uop_valid"},  32'(uop_valid),  32'(e_valid));
    chk({ctx, ".uop_reg"},    32'(uop_reg),    32'(e_reg));
    chk({ctx, ".uop_load"},   32'(uop_load),   32'(e_load));
    chk({ctx, ".uop_first"},  32'(uop_first),  32'(e_first));
    chk({ctx, ".uop_last"},   32'(uop_last),   32'(e_last));
    chk({ctx, ".uop_offset"}, uop_offset,      e_off);
    chk({ctx, ".uop_wb"},     32'(uop_wb),     32'(e_wb));
    if (e_cmp_wbo) chk({ctx, ".wb_offset"}, wb_offset, e_wbo);
  endtask

  // Presents one instruction and follows it through all of its micro-ops.
  // stall_at/flush_at name the micro-op index before which the event occurs.
  task automatic run_instr(input string name, input logic [31:0] ins, input logic arm,
                           input int stall_at, input int stall_len, input int flush_at);
    logic [3:0] regs[$];
    int n, start, k, stl;
    logic det;
    regs = {};
    for (int i = 0; i < 16; i++) if (ins[i]) regs.push_back(4'(i));
    n     = regs.size();
    det   = arm && (ins[27:25] == 3'b100);
    start = ins[23] ? 0 : -4 * n;
    if (ins[24] == ins[23]) start += 4;
    if (!det || n == 0) begin
      @(negedge clk);
      armD = arm; validD = 1; instrD = ins; stallD = 0; flushD = 0;
      #1;
      set_zero();
      check_all({name, ".nop"});
      return;
    end
    k   = 0;
    stl = stall_len;
    while (k < n) begin
      @(negedge clk);
      armD = 1; validD = 1; stallD = 0; flushD = 0;
      instrD = (k == 0) ? ins : $urandom;
      if (k == flush_at) begin
        flushD = 1;
        #1;
        chk({name, ".flush.uop_valid"}, 32'(uop_valid), 32'd0);
        @(negedge clk);
        flushD = 0; armD = 0; instrD = $urandom;
        #1;
        set_zero();
        check_all({name, ".post_flush"});
        return;
      end else if (k == stall_at && stl > 0) begin
        stallD = 1;
        stl--;
        #1;
        e_valid = 0;
        check_all({name, ".stall"});
      end else begin
        #1;
        e_valid   = 1;
        e_reg     = regs[k];
        e_load    = ins[20];
        e_first   = (k == 0);
        e_last    = (k == n - 1);
        e_off     = 32'(start + 4 * k);
        e_wb      = ins[21] && e_last;
        e_stall   = (k < n - 1);
        e_wbo     = ins[23] ? 32'(4 * n) : 32'(-4 * n);
        e_cmp_wbo = e_last && e_wb;
        check_all($sformatf("%s.uop%0d", name, k));
        k++;
      end
    end
  endtask

  initial begin
    logic [31:0] ins;
    logic        arm;
    int          sel;

    armD = 1; validD = 1; instrD = 32'hE8B00026;
    #3;
    set_zero();
    check_all("reset");
    @(negedge clk);
    reset_n = 1; armD = 0;

    run_instr("ldmia",   32'hE8B00026, 1, -1, 0, -1);
    run_instr("stmdb",   32'hE92D4010, 1, -1, 0, -1);
    run_instr("ldmib16", 32'hE993FFFF, 1, -1, 0, -1);
    run_instr("stmda",   32'hE8058421, 1, -1, 0, -1);
    run_instr("single",  32'hE8900004, 1, -1, 0, -1);
    run_instr("empty",   32'hE8B00000, 1, -1, 0, -1);
    run_instr("riscv",   32'hE8B00026, 0, -1, 0, -1);
    run_instr("stall8",  32'hE89100FF, 1, 3, 2, -1);
    run_instr("flush8",  32'hE89100FF, 1, 3, 2, 4);

    // Asynchronous reset between clock edges, mid-sequence.
    @(negedge clk);
    armD = 1; validD = 1; instrD = 32'hE8B000FF;
    @(negedge clk);
    instrD = $urandom;
    #2;
    reset_n = 0;
    #1;
    set_zero();
    check_all("async_reset");
    @(negedge clk);
    reset_n = 1; armD = 0;
    run_instr("after_reset", 32'hE8B000FF, 1, -1, 0, -1);

    for (int t = 0; t < 60; t++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[27:25] = 3'b100;
      sel = $urandom_range(0, 7);
      if (sel == 0)      ins[15:0] = 16'(1 << $urandom_range(0, 15));
      else if (sel == 1) ins[15:0] = '0;
      else if (sel < 4)  ins[15:0] = 16'($urandom) & 16'($urandom);
      arm = ($urandom_range(0, 9) != 0);
      run_instr($sformatf("rnd%0d", t), ins, arm,
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, 16) : -1,
                $urandom_range(1, 3),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ldm_sequencer.md
# ldm_sequencer

Decode-stage micro-op sequencer for ARM block data transfers (LDM/STM) in the combined ARM/RISC-V core. When an ARM LDM/STM sits in Decode, it expands the 16-bit register list into one single-register load/store micro-op per cycle. Each micro-op carries a byte offset from the base register. The sequencer stalls Fetch/Decode until the last micro-op issues and flags base write-back on the last micro-op. RISC-V instructions and all other ARM instructions pass through untouched.

## Interface
- No parameters.
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- armD  in  1  Decode instruction is ARM (1) or RISC-V (0)
- validD  in  1  Decode holds a live instruction
- instrD  in  32  Decode instruction word
- stallD  in  1  hazard-unit stall of Decode; sequencer freezes
- flushD  in  1  hazard-unit flush of Decode; sequencer aborts
- seq_stall  out  1  stall request to Fetch/Decode (more micro-ops pending)
- uop_valid  out  1  micro-op valid this cycle
- uop_reg  out  4  transfer register Rd for this micro-op
- uop_load  out  1  1 = load (L bit), 0 = store
- uop_first  out  1  first micro-op of the instruction
- uop_last  out  1  last micro-op of the instruction
- uop_offset  out  32  signed byte offset added to Rn for this micro-op
- uop_wb  out  1  write back Rn (W bit); asserted only with uop_last
- wb_offset  out  32  signed value added to Rn on write-back (+4n if U=1, -4n if U=0)

## Operation
- Detect: armD & validD & instrD[27:25]==3'b100. Fields: P=[24], U=[23], W=[21], L=[20], Rn=[19:16], list=[15:0], n=popcount(list).
- The S bit [22] and the condition field are ignored. Downstream predication handles the condition.
- States: IDLE and SEQ.
- IDLE
  - On detect with n≥1, emit micro-op 0 combinationally from instrD in the same cycle.
  - If n>1: latch the remaining mask (list with its lowest set bit cleared), U/P/W/L/Rn, n and the next offset; assert seq_stall; go to SEQ.
  - If n==1: uop_first=uop_last=1; stay in IDLE.
- SEQ
  - Each cycle, emit the lowest set bit of the remaining mask, clear it, and add 4 to the offset.
  - When the remaining mask has exactly one bit, that micro-op is last. Deassert seq_stall in that cycle and return to IDLE.
- Register order is always ascending register number. The lowest register gets the lowest address.
- Start offset:
  - IA (P=0,U=1): 0
  - IB (P=1,U=1): +4
  - DA (P=0,U=0): -4n+4
  - DB (P=1,U=0): -4n
  - Micro-op k gets start + 4k.
- All offset arithmetic is 32-bit two's complement; n ≤ 16, so |offset| ≤ 64.
- Empty list (n==0): no micro-op, no stall, no write-back. The instruction behaves as a NOP.
- Non-detect (including armD=0 with any bits): every output is 0.

## Timing
- Latency 0: micro-op 0 appears in the cycle the instruction is first in Decode.
- Micro-op k appears k cycles later, absent stalls. Total occupancy is n cycles, and seq_stall is high for n-1 cycles.
- When stallD=1:
  - State, mask and offset hold.
  - uop_valid=0; other outputs hold their values.
  - seq_stall keeps its value.
- flushD=1 has priority over stallD. The next state is IDLE, the latched mask is cleared, and uop_valid=0 in that cycle.
- While in SEQ, instrD is ignored. Fetch/Decode are held by seq_stall.
- The instruction after the LDM/STM is accepted in the cycle after uop_last.
- Reset (asynchronous, any time including mid-sequence) puts the state in IDLE and sets all outputs and registers to 0.

## Test plan
- LDMIA r0!,{r1,r2,r5}, instrD=0xE8B00026, armD=1:
  - 3 micro-ops, uop_reg 1,2,5, offsets 0,4,8, uop_load=1.
  - seq_stall high for cycles 0-1.
  - The last micro-op has uop_wb=1 and wb_offset=12.
- STMDB sp!,{r4,lr}, instrD=0xE92D4010:
  - uop_reg 4,14, offsets -8,-4, uop_load=0.
  - uop_wb=1 and wb_offset=-8 (0xFFFFFFF8) on the 2nd micro-op.
- LDMIB r3,{r0-r15}, list 0xFFFF, W=0:
  - 16 micro-ops, offsets 4..64.
  - seq_stall high for 15 cycles, uop_wb=0.
- Single-register and empty lists:
  - A single-register list gives one micro-op with uop_first=uop_last=1 and no stall.
  - List 0x0000 gives no micro-op.
  - armD=0 with instrD=0xE8B00026 gives every output 0.
- Stall and flush during an 8-register LDM:
  - stallD for 2 cycles after micro-op 2: uop_reg and offset are frozen and uop_valid=0, then the sequence resumes with micro-op 3.
  - flushD at micro-op 4: IDLE next cycle, seq_stall=0, no further micro-ops.
- reset_n low mid-sequence (asynchronous, between clock edges): outputs go 0 immediately. After release, the next LDM starts from micro-op 0.
